// File: rtl/circuito_pkg.sv
// circuito_pkg: state encoding and time-base constants shared by the pulse
// generator and the downstream capacitor stage.
package circuito_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RISE = 3'd1,
        HOLD = 3'd2,
        FALL = 3'd3,
        GAP  = 3'd4
    } pulse_state_t;

    localparam real TS_DEFAULT = 4e-9;
    localparam real C_DEFAULT  = 100e-9;

endpackage

// File: rtl/current_pulse_gen_phase_timer.sv
// phase_timer: loadable down-counter timing one phase; last_o marks the final
// cycle of the loaded length.
module phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign count_o = cnt_q;
    assign last_o  = (cnt_q == W'(1));

endmodule

// File: rtl/current_pulse_gen.sv
// current_pulse_gen: train of N trapezoidal current pulses, one sample per clk.
// Build option CURRENT_PULSE_ALT_POL_EN negates every even-numbered pulse.
module current_pulse_gen
    import circuito_pkg::*;
#(
    parameter real         TS       = TS_DEFAULT,
    parameter real         I_MAX    = 1e-3,
    parameter int unsigned RAMP_CYC = 16,
    parameter int unsigned HOLD_CYC = 64,
    parameter int unsigned GAP_CYC  = 32,
    parameter int unsigned N_PULSES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output real        i_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] pulse_cnt,
    output logic [2:0] phase
);

    localparam int unsigned TW = 16;
    localparam real RAMP_DIV = (RAMP_CYC == 0) ? 1.0 : real'(RAMP_CYC);
    // Illegal parameter sets never leave IDLE.
    localparam bit CFG_OK = (TS > 0.0) && (HOLD_CYC >= 1) && (GAP_CYC >= 1) &&
                            (N_PULSES >= 1) && (N_PULSES <= 255);

    localparam pulse_state_t FIRST_ST  = (RAMP_CYC == 0) ? HOLD : RISE;
    localparam logic [TW-1:0] FIRST_LEN = (RAMP_CYC == 0) ? TW'(HOLD_CYC) : TW'(RAMP_CYC);
    localparam pulse_state_t POST_HOLD_ST  = (RAMP_CYC == 0) ? GAP : FALL;
    localparam logic [TW-1:0] POST_HOLD_LEN = (RAMP_CYC == 0) ? TW'(GAP_CYC) : TW'(RAMP_CYC);

    pulse_state_t  state_q, state_d;
    real           i_q, i_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_val, tmr_count, rem_d;
    logic          tmr_last;
    int            k_d;

    phase_timer #(.W(TW)) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_o    (tmr_count),
        .last_o     (tmr_last)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        unique case (state_q)
            IDLE: if (start && CFG_OK) begin
                state_d      = FIRST_ST;
                cnt_d        = 8'd1;
                tmr_load     = 1'b1;
                tmr_load_val = FIRST_LEN;
            end
            RISE: if (tmr_last) begin
                state_d      = HOLD;
                tmr_load     = 1'b1;
                tmr_load_val = TW'(HOLD_CYC);
            end
            HOLD: if (tmr_last) begin
                state_d      = POST_HOLD_ST;
                tmr_load     = 1'b1;
                tmr_load_val = POST_HOLD_LEN;
            end
            FALL: if (tmr_last) begin
                state_d      = GAP;
                tmr_load     = 1'b1;
                tmr_load_val = TW'(GAP_CYC);
            end
            GAP: if (tmr_last) begin
                if (cnt_q < 8'(N_PULSES)) begin
                    state_d      = FIRST_ST;
                    cnt_d        = cnt_q + 8'd1;
                    tmr_load     = 1'b1;
                    tmr_load_val = FIRST_LEN;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a start seen in IDLE.
        if (abort) begin
            state_d      = IDLE;
            cnt_d        = cnt_q;
            done_d       = 1'b0;
            tmr_load     = 1'b0;
            tmr_load_val = '0;
        end
    end

    // Next sample is derived from the step index k, never accumulated.
    always_comb begin
        rem_d = tmr_load ? tmr_load_val : (tmr_count - TW'(1));
        k_d   = int'(RAMP_CYC) - int'(rem_d) + 1;
        i_d   = 0.0;
        case (state_d)
            RISE:    i_d = I_MAX * real'(k_d) / RAMP_DIV;
            HOLD:    i_d = I_MAX;
            FALL:    i_d = I_MAX * real'(int'(RAMP_CYC) - k_d) / RAMP_DIV;
            default: i_d = 0.0;
        endcase
`ifdef CURRENT_PULSE_ALT_POL_EN
        if (!cnt_d[0]) begin
            i_d = -i_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 0.0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign i_out     = i_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = cnt_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_current_pulse_gen.sv
// tb_current_pulse_gen: scoreboard bench for current_pulse_gen with a trapezoidal
// capacitor model on the default instance and a short step-edged instance.
module tb_current_pulse_gen;
    import circuito_pkg::*;

    localparam real I_MAX = 1e-3;
    localparam int  R = 16, H = 64, G = 32, N = 4;
    localparam int  PULSE_LEN = 2 * R + H + G;

    typedef struct {
        real          i;
        logic         busy;
        logic         done;
        int           pcnt;
        pulse_state_t phase;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start_a, abort_a, start_b, abort_b;
    real        i_a, i_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] cnt_a, cnt_b;
    logic [2:0] ph_a, ph_b;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    real  v_cap = 0.0;
    real  i_prev = 0.0;

    always #5 clk = ~clk;

    current_pulse_gen #(
        .TS(TS_DEFAULT), .I_MAX(I_MAX), .RAMP_CYC(R), .HOLD_CYC(H),
        .GAP_CYC(G), .N_PULSES(N)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .i_out(i_a), .busy(busy_a), .done(done_a), .pulse_cnt(cnt_a), .phase(ph_a)
    );

    current_pulse_gen #(
        .TS(TS_DEFAULT), .I_MAX(I_MAX), .RAMP_CYC(0), .HOLD_CYC(4),
        .GAP_CYC(2), .N_PULSES(2)
    ) u_dut_s (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .i_out(i_b), .busy(busy_b), .done(done_b), .pulse_cnt(cnt_b), .phase(ph_b)
    );

    task automatic check(input string tag, input real got, input real exp);
        total++;
        if ((got - exp > 1e-12) || (exp - got > 1e-12)) begin
            bad++;
            $display("FAIL %s: got %.15g expected %.15g", tag, got, exp);
        end
    endtask

    task automatic push_e(input real i, input logic b, input logic d, input int pc,
                          input pulse_state_t ph);
        exp_t e;
        e.i = i; e.busy = b; e.done = d; e.pcnt = pc; e.phase = ph;
        sb.push_back(e);
    endtask

    // Expected sample stream of one complete run, starting with cycle 1.
    task automatic push_run(input int r, input int h, input int g, input int n);
        real s;
        for (int p = 1; p <= n; p++) begin
            s = 1.0;
`ifdef CURRENT_PULSE_ALT_POL_EN
            if (p % 2 == 0) s = -1.0;
`endif
            for (int k = 1; k <= r; k++) push_e(s * (I_MAX * real'(k) / real'(r)), 1'b1, 1'b0, p, RISE);
            for (int k = 1; k <= h; k++) push_e(s * I_MAX, 1'b1, 1'b0, p, HOLD);
            for (int k = 1; k <= r; k++) push_e(s * (I_MAX * real'(r - k) / real'(r)), 1'b1, 1'b0, p, FALL);
            for (int k = 1; k <= g; k++) push_e(0.0, 1'b1, 1'b0, p, GAP);
        end
        push_e(0.0, 1'b0, 1'b1, n, IDLE);
        push_e(0.0, 1'b0, 1'b0, n, IDLE);
    endtask

    task automatic check_out(input string tag, input real gi, input logic gb, input logic gd,
                             input logic [7:0] gc, input logic [2:0] gp,
                             input real i, input logic b, input logic d, input int pc, input int ph);
        check({tag, ".i_out"}, gi, i);
        check({tag, ".busy"}, real'(gb), real'(b));
        check({tag, ".done"}, real'(gd), real'(d));
        check({tag, ".pulse_cnt"}, real'(gc), real'(pc));
        check({tag, ".phase"}, real'(gp), real'(ph));
    endtask

    task automatic pop_a(input int c);
        exp_t e;
        e = sb.pop_front();
        check_out($sformatf("a%0d", c), i_a, busy_a, done_a, cnt_a, ph_a,
                  e.i, e.busy, e.done, e.pcnt, int'(e.phase));
    endtask

    task automatic pop_b(input int c);
        exp_t e;
        e = sb.pop_front();
        check_out($sformatf("b%0d", c), i_b, busy_b, done_b, cnt_b, ph_b,
                  e.i, e.busy, e.done, e.pcnt, int'(e.phase));
    endtask

    function automatic real exp_v(input int p);
`ifdef CURRENT_PULSE_ALT_POL_EN
        return (p % 2 == 1) ? 3.2e-3 : 0.0;
`else
        return 3.2e-3 * real'(p);
`endif
    endfunction

    initial begin
        rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        repeat (3) @(negedge clk);
        check_out("rst_a", i_a, busy_a, done_a, cnt_a, ph_a, 0.0, 1'b0, 1'b0, 0, int'(IDLE));
        check_out("rst_b", i_b, busy_b, done_b, cnt_b, ph_b, 0.0, 1'b0, 1'b0, 0, int'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Full default run with capacitor integration and a start while busy.
        push_run(R, H, G, N);
        start_a = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            start_a = (c == 200);
            if (c == 1) check("first_sample", i_a, 62.5e-6);
            if (c == 16 || c == 80) check($sformatf("plateau%0d", c), i_a, I_MAX);
`ifdef CURRENT_PULSE_ALT_POL_EN
            if (c == PULSE_LEN + 40) check("neg_plateau", i_a, -I_MAX);
`endif
            pop_a(c);
            v_cap  = v_cap + (TS_DEFAULT / C_DEFAULT) * (i_prev + i_a) / 2.0;
            i_prev = i_a;
            if (c % PULSE_LEN == 0 && c <= N * PULSE_LEN)
                check($sformatf("vout_p%0d", c / PULSE_LEN), v_cap, exp_v(c / PULSE_LEN));
        end
        check("vout_done", v_cap, exp_v(N));

        // Step-edged instance: plateau 4, gap 2, two pulses.
        push_run(0, 4, 2, 2);
        start_b = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            pop_b(c);
        end

        // Abort in the hold phase of pulse 2.
        push_run(R, H, G, N);
        start_a = 1'b1;
        for (int c = 1; c <= PULSE_LEN + R + 10; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            pop_a(c);
        end
        sb.delete();
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_out("abort", i_a, busy_a, done_a, cnt_a, ph_a, 0.0, 1'b0, 1'b0, 2, int'(IDLE));
        @(negedge clk);
        check_out("abort_idle", i_a, busy_a, done_a, cnt_a, ph_a, 0.0, 1'b0, 1'b0, 2, int'(IDLE));
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check_out("abort_wins", i_a, busy_a, done_a, cnt_a, ph_a, 0.0, 1'b0, 1'b0, 2, int'(IDLE));

        // Restart after abort begins again at pulse 1.
        push_run(R, H, G, N);
        start_a = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            pop_a(c);
        end

        // Reset during the fall ramp, with start in the same cycle.
        push_run(R, H, G, N);
        start_a = 1'b1;
        for (int c = 1; c <= 2 * PULSE_LEN - G - 8; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            pop_a(c);
        end
        sb.delete();
        rst = 1'b1; start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0;
        check_out("rst_fall", i_a, busy_a, done_a, cnt_a, ph_a, 0.0, 1'b0, 1'b0, 0, int'(IDLE));
        @(negedge clk);
        check_out("rst_start_ign", i_a, busy_a, done_a, cnt_a, ph_a, 0.0, 1'b0, 1'b0, 0, int'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
